bus_seq_ctrl: RTL and testbench
===============================

// Module: bus_seq_ctrl
// PURPOSE
//  Multi-cycle control sequencer for the 3-bit shared-bus datapath (R0-R7, A, ALU, G, data buffer).
//  Accepts one instruction per start/done handshake and drives the register in/out enables,
//  data buffer enable, A/G enables and the one-hot ALU op enables.
//  Guarantees at most one bus driver per cycle and counts retired instructions.
// PARAMETERS
//  NUM_REGS  8  number of general registers; fixed at 8 by the one-hot r_in/r_out mapping
//  IDX_W     3  register index width (rx, ry)
//  CNT_W     8  width of the retired-instruction counter
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      instruction request; sampled only in IDLE
//  func         in   4      opcode; latched with start
//  rx           in   IDX_W  destination / first operand register index
//  ry           in   IDX_W  source / second operand register index
//  busy         out  1      high from the first execute step through the final step
//  done         out  1      one-cycle pulse during the final step (including ERR)
//  err          out  1      one-cycle pulse in ERR (illegal func)
//  data_out     out  1      enables the external data buffer onto the bus
//  r_in         out  8      register load enables; Rk <-> bit (7-k)
//  r_out        out  8      register bus-drive enables; Rk <-> bit (7-k)
//  a_in         out  1      A register load enable
//  g_in         out  1      G register load enable
//  g_out        out  1      G bus-drive enable
//  math_en      out  7      one-hot ALU op: [6]add [5]sub [4]and [3]or [2]xor [1]div [0]mod
//  instr_count  out  CNT_W  instructions retired since reset (ERR excluded)
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - Reset (any state, including mid-instruction): state=IDLE, latched func/rx/ry=0,
//    instr_count=0, all outputs 0. Writes already done by earlier steps stay in place.
//  - Outputs are Moore, decoded from the state and the latched func/rx/ry.
//  - In IDLE all enables are 0.
//  - IDLE: if start=1 at a clock edge, latch func/rx/ry and go to T1 (legal func) or ERR.
//    The first step is active in the cycle after the start edge.
//  - start outside IDLE is ignored; no queueing. func/rx/ry changes after latch have no effect.
//  - func 0001 LOAD rx <- data. T1: data_out=1, r_in[rx]=1, done=1. Then IDLE.
//  - func 0010 MOVE rx <- ry. T1: r_out[ry]=1, r_in[rx]=1, done=1. Then IDLE.
//  - func 0011-1001 ALU ops add, sub, and, or, xor, div, mod, in that order:
//      T1: r_out[rx]=1, a_in=1
//      T2: r_out[ry]=1, math_en[op]=1, g_in=1
//      T3: g_out=1, r_in[rx]=1, done=1; then IDLE
//  - Latency from start edge to done: 1 cycle for LOAD/MOVE, 3 cycles for ALU ops.
//    Next start is accepted at the edge that ends the done cycle's successor (IDLE).
//  - func 0000 or 1010-1111: one ERR cycle with err=1, done=1, no enables, no count; then IDLE.
//  - busy=1 in T1/T2/T3 and ERR; done and busy are coincident in the final step.
//  - instr_count increments by 1 on the edge leaving a legal final step.
//    It wraps 2^CNT_W-1 -> 0 with no flag.
//  - rx==ry is legal. MOVE R3,R3 is a self-copy. ALU R2,R2 uses R2 for both operands.
//  - Bus invariant, every cycle: data_out + |r_out + g_out <= 1 driver, and r_out/r_in
//    each have at most one bit set. math_en has at most one bit set and is 0 outside T2.
// TESTING
//  - rst_n=0 mid-T2 of ADD: all outputs 0 immediately; after release, busy=0 and instr_count=0.
//  - LOAD: start, func=0001, rx=5 -> next cycle data_out=1, r_in=8'b0000_0100, done=1;
//    instr_count=1 after that edge.
//  - MOVE: func=0010, rx=2, ry=0 -> single cycle with r_out=8'b1000_0000,
//    r_in=8'b0010_0000, done=1.
//  - MOD: func=1001, rx=1, ry=4 ->
//      T1 r_out=0100_0000 + a_in
//      T2 r_out=0000_1000 + math_en=0000001 + g_in
//      T3 g_out + r_in=0100_0000 + done
//  - Illegal func=1111 -> one cycle err=1, done=1, all enables 0, instr_count unchanged.
//    start held high during a SUB -> exactly one SUB executes.
//  - 256 back-to-back LOADs (CNT_W=8) -> instr_count wraps to 0.
//    Bus-invariant assertion holds across a random instruction stream.

Source files
------------

// File: rtl/bus_seq_ctrl.sv
// Multi-cycle control sequencer for the shared-bus register/ALU datapath.
// One instruction per start/done handshake; Moore outputs decoded from state and latched fields.
module bus_seq_ctrl #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [3:0]          func,
    input  logic [IDX_W-1:0]    rx,
    input  logic [IDX_W-1:0]    ry,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                data_out,
    output logic [NUM_REGS-1:0] r_in,
    output logic [NUM_REGS-1:0] r_out,
    output logic                a_in,
    output logic                g_in,
    output logic                g_out,
    output logic [6:0]          math_en,
    output logic [CNT_W-1:0]    instr_count
);

    localparam logic [3:0] FuncLoad = 4'd1;
    localparam logic [3:0] FuncMove = 4'd2;
    localparam logic [3:0] FuncAdd  = 4'd3;
    localparam logic [3:0] FuncMod  = 4'd9;

    typedef enum logic [2:0] {StIdle, StT1, StT2, StT3, StErr} state_e;

    state_e           state_q, state_d;
    logic [3:0]       func_q;
    logic [IDX_W-1:0] rx_q, ry_q;
    logic             is_legal, is_short, retire;

    // R0 maps to the MSB of the enable vectors.
    function automatic logic [NUM_REGS-1:0] reg_sel(input logic [IDX_W-1:0] idx);
        reg_sel = {1'b1, {(NUM_REGS-1){1'b0}}} >> idx;
    endfunction

    assign is_legal = (func >= FuncLoad) && (func <= FuncMod);
    assign is_short = (func_q == FuncLoad) || (func_q == FuncMove);
    assign retire   = ((state_q == StT1) && is_short) || (state_q == StT3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            func_q      <= '0;
            rx_q        <= '0;
            ry_q        <= '0;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && start) begin
                func_q <= func;
                rx_q   <= rx;
                ry_q   <= ry;
            end
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = is_legal ? StT1 : StErr;
                end
            end
            StT1:    state_d = is_short ? StIdle : StT2;
            StT2:    state_d = StT3;
            StT3:    state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        data_out = 1'b0;
        r_in     = '0;
        r_out    = '0;
        a_in     = 1'b0;
        g_in     = 1'b0;
        g_out    = 1'b0;
        math_en  = '0;
        unique case (state_q)
            StT1: begin
                busy = 1'b1;
                if (func_q == FuncLoad) begin
                    data_out = 1'b1;
                    r_in     = reg_sel(rx_q);
                    done     = 1'b1;
                end else if (func_q == FuncMove) begin
                    r_out = reg_sel(ry_q);
                    r_in  = reg_sel(rx_q);
                    done  = 1'b1;
                end else begin
                    r_out = reg_sel(rx_q);
                    a_in  = 1'b1;
                end
            end
            StT2: begin
                busy    = 1'b1;
                r_out   = reg_sel(ry_q);
                math_en = 7'b100_0000 >> (func_q - FuncAdd);
                g_in    = 1'b1;
            end
            StT3: begin
                busy  = 1'b1;
                g_out = 1'b1;
                r_in  = reg_sel(rx_q);
                done  = 1'b1;
            end
            StErr: begin
                busy = 1'b1;
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_seq_ctrl.sv
// Self-checking bench for bus_seq_ctrl: directed cases then a random instruction stream
// compared cycle by cycle against a table-driven model of the instruction step rules.
`timescale 1ns/1ps
module tb_bus_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] func;
    logic [2:0] rx, ry;
    logic       busy, done, err, data_out, a_in, g_in, g_out;
    logic [7:0] r_in, r_out, instr_count;
    logic [6:0] math_en;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] cnt_m = 8'd0;

    bus_seq_ctrl #(.NUM_REGS(8), .IDX_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func(func), .rx(rx), .ry(ry),
        .busy(busy), .done(done), .err(err), .data_out(data_out), .r_in(r_in),
        .r_out(r_out), .a_in(a_in), .g_in(g_in), .g_out(g_out), .math_en(math_en),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    wire [29:0] obs = {busy, done, err, data_out, r_in, r_out, a_in, g_in, g_out, math_en};

    function automatic logic [29:0] pk(input logic b, d, e, dout, input logic [7:0] ri, ro,
                                       input logic ai, gi, go, input logic [6:0] m);
        pk = {b, d, e, dout, ri, ro, ai, gi, go, m};
    endfunction

    // Register k drives bit (7-k).
    function automatic logic [7:0] rb(input int k);
        rb = 8'(1 << (7 - k));
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic check_bus(input string tag);
        logic ok;
        ok = (int'(data_out) + $countones(r_out) + int'(g_out) <= 1) &&
             $onehot0(r_in) && $onehot0(r_out) && $onehot0(math_en);
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    // Called right after a negedge; returns right after the negedge of the following IDLE cycle.
    task automatic run_instr(input string tag, input logic [3:0] f, input int x, input int y,
                             input bit hold);
        logic [29:0] steps[$];
        bit legal;
        legal = (f >= 4'd1) && (f <= 4'd9);
        if (!legal)
            steps.push_back(pk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        else if (f == 4'd1)
            steps.push_back(pk(1, 1, 0, 1, rb(x), 0, 0, 0, 0, 0));
        else if (f == 4'd2)
            steps.push_back(pk(1, 1, 0, 0, rb(x), rb(y), 0, 0, 0, 0));
        else begin
            steps.push_back(pk(1, 0, 0, 0, 0, rb(x), 1, 0, 0, 0));
            steps.push_back(pk(1, 0, 0, 0, 0, rb(y), 0, 1, 0, 7'(1 << (6 - (int'(f) - 3)))));
            steps.push_back(pk(1, 1, 0, 0, rb(x), 0, 0, 0, 1, 0));
        end
        start = 1'b1;
        func  = f;
        rx    = 3'(x);
        ry    = 3'(y);
        foreach (steps[i]) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            func = 4'($urandom);
            rx   = 3'($urandom);
            ry   = 3'($urandom);
            check({tag, "_step"}, {2'b0, obs}, {2'b0, steps[i]});
            check_bus({tag, "_bus"});
        end
        if (legal) cnt_m = cnt_m + 8'd1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_idle"}, {2'b0, obs}, 32'd0);
        check({tag, "_cnt"}, {24'd0, instr_count}, {24'd0, cnt_m});
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        func  = '0;
        rx    = '0;
        ry    = '0;
        repeat (2) @(negedge clk);
        check("reset_outs", {2'b0, obs}, 32'd0);
        check("reset_cnt", {24'd0, instr_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_instr("load_r5", 4'd1, 5, 0, 1'b0);
        check("load_r5_rin", {24'd0, rb(5)}, 32'h04);
        run_instr("move_r2_r0", 4'd2, 2, 0, 1'b0);
        run_instr("mod_r1_r4", 4'd9, 1, 4, 1'b0);
        run_instr("illegal_f", 4'hF, 3, 6, 1'b0);
        run_instr("illegal_0", 4'h0, 0, 0, 1'b0);
        run_instr("sub_hold", 4'd4, 6, 2, 1'b1);
        // start is low now; nothing must launch on the following edge
        @(negedge clk);
        check("sub_hold_once", {2'b0, obs}, 32'd0);
        check("sub_hold_cnt", {24'd0, instr_count}, {24'd0, cnt_m});
        run_instr("move_self", 4'd2, 3, 3, 1'b0);
        run_instr("add_self", 4'd3, 2, 2, 1'b0);

        // Asynchronous reset in the middle of an ADD
        start = 1'b1; func = 4'd3; rx = 3'd0; ry = 3'd7;
        @(negedge clk);
        start = 1'b0;
        check("rst_add_t1", {2'b0, obs}, {2'b0, pk(1, 0, 0, 0, 0, rb(0), 1, 0, 0, 0)});
        @(negedge clk);
        check("rst_add_t2", {2'b0, obs}, {2'b0, pk(1, 0, 0, 0, 0, rb(7), 0, 1, 0, 7'b100_0000)});
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outs", {2'b0, obs}, 32'd0);
        check("rst_async_cnt", {24'd0, instr_count}, 32'd0);
        cnt_m = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel_busy", {31'd0, busy}, 32'd0);
        check("rst_rel_cnt", {24'd0, instr_count}, 32'd0);

        for (int i = 0; i < 256; i++) run_instr("wrap_load", 4'd1, i % 8, 0, 1'b0);
        check("wrap_cnt_zero", {24'd0, instr_count}, 32'd0);

        for (int i = 0; i < 300; i++) begin
            run_instr("rand", 4'($urandom), int'($urandom_range(7, 0)),
                      int'($urandom_range(7, 0)), 1'($urandom));
            if ($urandom_range(3, 0) == 0) begin
                @(negedge clk);
                check("rand_gap", {2'b0, obs}, 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
